// File: rtl/cpu_stage_sequencer_if.sv
// rtl/cpu_stage_sequencer_if.sv - handshake, decode-flag and stage/strobe bundle for the TinyCPU stage sequencer
interface cpu_stage_sequencer_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 run_en;
    logic                 mem_ready;
    logic                 is_load;
    logic                 is_store;
    logic                 writes_reg;
    logic                 is_halt;
    logic [2:0]           stage;
    logic                 instr_latch_en;
    logic                 mem_data_latch_en;
    logic                 reg_write_en;
    logic                 pc_write_en;
    logic                 halted;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] instr_count;

    // Core-side view: drives control inputs, consumes stage and strobes
    modport master (
        output run_en, mem_ready, is_load, is_store, writes_reg, is_halt,
        input  stage, instr_latch_en, mem_data_latch_en, reg_write_en,
               pc_write_en, halted, cycle_count, instr_count
    );

    // Sequencer-side view
    modport slave (
        input  run_en, mem_ready, is_load, is_store, writes_reg, is_halt,
        output stage, instr_latch_en, mem_data_latch_en, reg_write_en,
               pc_write_en, halted, cycle_count, instr_count
    );
endinterface

// File: rtl/cpu_stage_sequencer.sv
// rtl/cpu_stage_sequencer.sv - TinyCPU multi-cycle stage FSM; optional counters under PERF_COUNTERS_EN
module cpu_stage_sequencer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_stage_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        INSTR_FETCH     = 3'd0,
        MEMORY_READ     = 3'd1,
        REGISTER_UPDATE = 3'd2,
        MEMORY_WRITE    = 3'd3,
        PC_UPDATE       = 3'd4,
        HALTED          = 3'd5
    } stage_e;

    stage_e stage_q;
    stage_e stage_d;

    logic instr_latch;
    logic mem_data_latch;
    logic reg_write;
    logic pc_write;

    // Next-stage selection and same-cycle strobe decode; encodings 6/7 recover to fetch
    always_comb begin
        stage_d        = INSTR_FETCH;
        instr_latch    = 1'b0;
        mem_data_latch = 1'b0;
        reg_write      = 1'b0;
        pc_write       = 1'b0;
        case (stage_q)
            INSTR_FETCH: begin
                if (bus.run_en && bus.mem_ready) begin
                    instr_latch = 1'b1;
                    stage_d     = MEMORY_READ;
                end else begin
                    stage_d     = INSTR_FETCH;
                end
            end
            MEMORY_READ: begin
                if (bus.is_load) begin
                    if (bus.mem_ready) begin
                        mem_data_latch = 1'b1;
                        stage_d        = REGISTER_UPDATE;
                    end else begin
                        stage_d        = MEMORY_READ;
                    end
                end else begin
                    stage_d = REGISTER_UPDATE;
                end
            end
            REGISTER_UPDATE: begin
                reg_write = bus.writes_reg;
                stage_d   = bus.is_store ? MEMORY_WRITE : PC_UPDATE;
            end
            MEMORY_WRITE: begin
                stage_d = PC_UPDATE;
            end
            PC_UPDATE: begin
                pc_write = 1'b1;
                stage_d  = bus.is_halt ? HALTED : INSTR_FETCH;
            end
            HALTED: begin
                stage_d = HALTED;
            end
            default: begin
                stage_d = INSTR_FETCH;
            end
        endcase
    end

    // Stage register; reset abandons any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= INSTR_FETCH;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.stage             = stage_q;
    assign bus.instr_latch_en    = instr_latch;
    assign bus.mem_data_latch_en = mem_data_latch;
    assign bus.reg_write_en      = reg_write;
    assign bus.pc_write_en       = pc_write;
    assign bus.halted            = (stage_q == HALTED);

`ifdef PERF_COUNTERS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cycle_cnt_q;
    logic [CNT_WIDTH-1:0] instr_cnt_q;

    // Free-running cycle count and retire count (PC_UPDATE edges), both wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
            if (stage_q == PC_UPDATE) begin
                instr_cnt_q <= instr_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.cycle_count = cycle_cnt_q;
    assign bus.instr_count = instr_cnt_q;
`else
    assign bus.cycle_count = '0;
    assign bus.instr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// tb/tb_cpu_stage_sequencer.sv - scoreboard bench for cpu_stage_sequencer with instruction-level reference model
module tb_cpu_stage_sequencer;

    logic clk;
    logic rst_n;

    cpu_stage_sequencer_if #(.CNT_WIDTH(32)) bus ();

    cpu_stage_sequencer #(.CNT_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stage;
        logic        il;
        logic        ml;
        logic        rw;
        logic        pw;
        logic        hl;
        logic [31:0] cc;
        logic [31:0] ic;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cyc_m;
    logic [31:0] ic_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus the response the instruction-level model predicts for it
    task automatic step(input logic r, input logic m, input logic [2:0] s,
                        input logic il, input logic ml, input logic rw,
                        input logic pw, input logic hl);
        exp_t e;
        bus.run_en    = r;
        bus.mem_ready = m;
        e.stage = s;
        e.il = il; e.ml = ml; e.rw = rw; e.pw = pw; e.hl = hl;
`ifdef PERF_COUNTERS_EN
        e.cc = cyc_m;
        e.ic = ic_m;
`else
        e.cc = 32'd0;
        e.ic = 32'd0;
`endif
        sbq.push_back(e);
        cyc_m = cyc_m + 32'd1;
        if (s == 3'd4) ic_m = ic_m + 32'd1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // kind: 0 = run_en high / mem_ready low, 1 = run_en low / mem_ready high, 2 = random non-advancing
    task automatic do_instr(input logic ld, input logic st, input logic wr, input logic hl,
                            input int fw, input int rwt, input int kind, input logic rd_ready_low);
        logic [1:0] v;
        bus.is_load    = ld;
        bus.is_store   = st;
        bus.writes_reg = wr;
        bus.is_halt    = hl;
        for (int i = 0; i < fw; i++) begin
            if (kind == 0)      v = 2'b10;
            else if (kind == 1) v = 2'b01;
            else                v = 2'($urandom_range(0, 2));
            step(v[1], v[0], 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (ld) begin
            for (int i = 0; i < rwt; i++)
                step(rb(), 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(rb(), 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
            step(rb(), rd_ready_low ? 1'b0 : rb(), 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(rb(), rb(), 3'd2, 1'b0, 1'b0, wr, 1'b0, 1'b0);
        if (st) step(rb(), rb(), 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(rb(), rb(), 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (hl) begin
            for (int i = 0; i < 20; i++)
                step(rb(), rb(), 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic random_instrs(input int n);
        for (int k = 0; k < n; k++) begin
            do_instr(rb(), rb(), rb(), 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), 2, 1'b0);
        end
    endtask

    // Async reset with the clock high-phase in progress; outputs must clear before any edge
    task automatic async_reset_check();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stage",  32'(bus.stage), 32'd0);
        chk("async_rst_halted", 32'(bus.halted), 32'd0);
        chk("async_rst_pcw",    32'(bus.pc_write_en), 32'd0);
        chk("async_rst_cc",     bus.cycle_count, 32'd0);
        chk("async_rst_ic",     bus.instr_count, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        cyc_m = 32'd0;
        ic_m  = 32'd0;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected record per cycle, compared away from the rising edge
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("stage",             32'(bus.stage),             32'(e.stage));
            chk("instr_latch_en",    32'(bus.instr_latch_en),    32'(e.il));
            chk("mem_data_latch_en", 32'(bus.mem_data_latch_en), 32'(e.ml));
            chk("reg_write_en",      32'(bus.reg_write_en),      32'(e.rw));
            chk("pc_write_en",       32'(bus.pc_write_en),       32'(e.pw));
            chk("halted",            32'(bus.halted),            32'(e.hl));
            chk("cycle_count",       bus.cycle_count,            e.cc);
            chk("instr_count",       bus.instr_count,            e.ic);
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.run_en     = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.is_load    = 1'b0;
        bus.is_store   = 1'b0;
        bus.writes_reg = 1'b0;
        bus.is_halt    = 1'b0;
        cyc_m = 32'd0;
        ic_m  = 32'd0;

        #2;
        chk("reset_stage",  32'(bus.stage), 32'd0);
        chk("reset_halted", 32'(bus.halted), 32'd0);
        chk("reset_cc",     bus.cycle_count, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three ALU instructions, everything ready: counters 12/3 on the following fetch
        for (int i = 0; i < 3; i++) do_instr(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 2, 1'b0);
        // Load: fetch waits 3 cycles on mem_ready, read waits 2
        do_instr(1'b1, 1'b0, 1'b1, 1'b0, 3, 2, 0, 1'b0);
        // Store, no register write, mem_ready low in MEMORY_READ
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2, 1'b1);
        // run_en low with mem_ready high for 5 cycles
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 5, 0, 1, 1'b0);

        random_instrs(60);

        // HALT parks for 20 cycles of toggling inputs, then async reset
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 2, 1'b0);
        async_reset_check();

        random_instrs(30);
        do_instr(1'b1, 1'b1, 1'b1, 1'b1, 2, 1, 2, 1'b0);
        async_reset_check();
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 2, 1'b0);

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
- Multi-cycle control FSM for the TinyCPU core.
- Generates the 3-bit `stage` bus consumed by main_memory_control, the register file and the PC logic.
- Waits on the main-memory ready handshake during read stages.
- Skips memory stages the current instruction does not need, and parks the core in HALTED on a halt instruction.

Parameters:
- CNT_WIDTH, 32, width of the performance counters (only meaningful with PERF_COUNTERS_EN).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run_en  input  1  allows a new instruction to leave INSTR_FETCH.
- mem_ready  input  1  main memory has valid read data this cycle.
- is_load  input  1  decoded instruction reads memory; valid from the cycle after the instruction latch.
- is_store  input  1  decoded instruction writes memory; same validity.
- writes_reg  input  1  decoded instruction writes the register file; same validity.
- is_halt  input  1  decoded instruction is HALT; same validity.
- stage  output  3  current stage: 0 INSTR_FETCH, 1 MEMORY_READ, 2 REGISTER_UPDATE, 3 MEMORY_WRITE, 4 PC_UPDATE, 5 HALTED.
- instr_latch_en  output  1  load the instruction register.
- mem_data_latch_en  output  1  load the memory-data register.
- reg_write_en  output  1  register-file write strobe.
- pc_write_en  output  1  PC register write strobe.
- halted  output  1  core is halted.
- cycle_count  output  CNT_WIDTH  cycles since reset.
- instr_count  output  CNT_WIDTH  retired instructions.

Behaviour:
- State register: 3 bits; `stage` drives it directly. Encodings 6 and 7 are unreachable; if entered, the next state is INSTR_FETCH.
- Reset (rst_n low, asynchronous): stage=0 immediately; all strobes 0; halted=0; counters 0. Reset asserted mid-instruction abandons that instruction, with no partial PC or register write.
- Strobes are combinational decodes of the current state and inputs, so they are valid in the same cycle. Each strobe is high for at most one cycle per instruction.
- INSTR_FETCH:
  - Advances only when run_en && mem_ready, then goes to MEMORY_READ.
  - instr_latch_en = run_en && mem_ready.
  - mem_ready without run_en is ignored; the state holds.
- MEMORY_READ:
  - Flags are now valid.
  - If is_load: hold until mem_ready; mem_data_latch_en = mem_ready; exit to REGISTER_UPDATE on mem_ready.
  - If !is_load: exactly one cycle, mem_ready ignored, no latch strobe, then REGISTER_UPDATE.
- REGISTER_UPDATE:
  - One cycle; reg_write_en = writes_reg.
  - Next state is MEMORY_WRITE if is_store, else PC_UPDATE.
- MEMORY_WRITE:
  - Exactly one cycle, with no wait; memory write_enable derives from stage==3.
  - Next state is PC_UPDATE.
- PC_UPDATE:
  - One cycle; pc_write_en=1.
  - Next state is HALTED if is_halt, else INSTR_FETCH.
- HALTED:
  - Absorbing; only rst_n leaves it.
  - halted=1; all strobes 0; all inputs ignored.
  - halted is a decode of stage==5.
- Minimum latency:
  - ALU instruction: 4 cycles (0,1,2,4).
  - Store: 5 cycles.
  - Load: 4 cycles plus memory wait cycles.
- Flags must be held stable by the decoder from MEMORY_READ through PC_UPDATE. The sequencer does not register them.

Optional Feature:
- PERF_COUNTERS_EN defined:
  - cycle_count increments every clock edge after reset, including HALTED, wrapping modulo 2^CNT_WIDTH.
  - instr_count increments on each edge where stage==PC_UPDATE, so a HALT instruction counts as retired; it also wraps.
  - Both counters are registered and reset to 0.
- PERF_COUNTERS_EN not defined: the cycle_count and instr_count ports remain and are tied to 0; no counter flops are inferred.

Test Plan:
- ALU instruction stream (is_load=0, is_store=0, writes_reg=1), mem_ready=1, run_en=1 from reset:
  - stage sequence 0,1,2,4,0 repeating.
  - reg_write_en high only in stage 2; pc_write_en high only in stage 4; instr_latch_en high only in stage 0.
- Load, mem_ready held low 3 cycles in FETCH and 2 cycles in READ:
  - stage=0 for 4 cycles, then 1 for 3 cycles.
  - instr_latch_en and mem_data_latch_en each pulse exactly once; total 9 cycles to return to stage 0.
- Store with writes_reg=0:
  - stages 0,1,2,3,4, with stage 3 for exactly one cycle.
  - reg_write_en never asserts.
  - stage 1 lasts one cycle even with mem_ready=0.
- run_en=0 with mem_ready=1 for 5 cycles:
  - stage stays 0 and instr_latch_en=0.
  - run_en set to 1: advances next edge.
- HALT instruction:
  - after stage 4, stage=5 and halted=1.
  - remains 5 for 20 cycles with mem_ready/run_en toggling.
  - rst_n low: stage=0 asynchronously, before the next clock edge.
- PERF_COUNTERS_EN defined, 3 ALU instructions from reset, mem_ready=1:
  - after 12 edges, cycle_count=12, instr_count=3.
  - with the macro undefined, both read 0.
